// File: rtl/uart_rx_buf_ctrl.sv
// uart_rx_buf_ctrl: FWFT receive FIFO with overrun tracking, idle timeout and level interrupt.
module uart_rx_buf_ctrl #(
  parameter int DEPTH          = 16,
  parameter int TICKS_PER_CHAR = 160,
  parameter int TO_W           = 4,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx_tick,
  input  logic            i_enable,
  input  logic            i_flush,
  input  logic            i_rx_done,
  input  logic [7:0]      i_rx_data,
  input  logic            i_rx_parity_err,
  output logic            o_rd_valid,
  input  logic            i_rd_ready,
  output logic [7:0]      o_rd_data,
  output logic            o_rd_perr,
  output logic [AW:0]     o_level,
  input  logic [AW:0]     i_thresh,
  input  logic [TO_W-1:0] i_timeout_chars,
  output logic            o_overrun,
  input  logic            i_overrun_clr,
  output logic            o_timeout,
  output logic            o_irq
);
  localparam int PW   = AW + 1;
  localparam int TC_W = $clog2(((2 ** TO_W) - 1) * TICKS_PER_CHAR + 1);

  typedef enum logic [1:0] {T_IDLE, T_COUNT, T_EXPIRED} t_state_e;

  logic [8:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_d;
  logic            full, wr_en, rd_fire, ovr_set, overrun_q, irq_q, restart;
  logic [TC_W-1:0] tc_q, tc_d, tc_lim;
  t_state_e        state_q, state_d;

  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_rd_valid = wr_ptr_q != rd_ptr_q;
  assign rd_fire    = o_rd_valid & i_rd_ready & ~i_flush;
  assign wr_en      = i_rx_done & i_enable & ~i_flush & (~full | rd_fire);
  assign ovr_set    = i_rx_done & i_enable & ~i_flush & full & ~rd_fire;
  assign {o_rd_perr, o_rd_data} = mem_q[rd_ptr_q[AW-1:0]];
  assign o_level    = wr_ptr_q - rd_ptr_q;
  assign level_d    = wr_ptr_d - rd_ptr_d;
  assign o_overrun  = overrun_q;
  assign o_timeout  = state_q == T_EXPIRED;
  assign o_irq      = irq_q;
  assign restart    = i_rx_done | rd_fire;
  assign tc_lim     = TC_W'(32'(i_timeout_chars) * TICKS_PER_CHAR - 1);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = i_flush ? wr_ptr_q : rd_ptr_q + PW'(rd_fire);
  end

  // Any activity (frame arrival or a read) restarts the idle count.
  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    case (state_q)
      T_IDLE: begin
        tc_d = '0;
        if (!i_flush && o_level != '0 && i_timeout_chars != '0) state_d = T_COUNT;
      end
      T_COUNT: begin
        if (i_flush || level_d == '0 || i_timeout_chars == '0) begin
          state_d = T_IDLE;
          tc_d    = '0;
        end else if (restart) begin
          tc_d = '0;
        end else if (rx_tick) begin
          state_d = (tc_q == tc_lim) ? T_EXPIRED : T_COUNT;
          tc_d    = (tc_q == tc_lim) ? '0 : tc_q + 1'b1;
        end
      end
      T_EXPIRED: begin
        if (i_flush || level_d == '0) begin
          state_d = T_IDLE;
          tc_d    = '0;
        end else if (restart) begin
          state_d = T_COUNT;
          tc_d    = '0;
        end
      end
      default: begin
        state_d = T_IDLE;
        tc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {i_rx_parity_err, i_rx_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
      state_q   <= T_IDLE;
      tc_q      <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= ovr_set ? 1'b1 : (i_overrun_clr ? 1'b0 : overrun_q);
      irq_q     <= (i_thresh != '0 && o_level >= i_thresh) | o_timeout | overrun_q;
      state_q   <= state_d;
      tc_q      <= tc_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_buf_ctrl.sv
// tb_uart_rx_buf_ctrl: scenario tasks plus a randomized run against a queue-based reference model.
module tb_uart_rx_buf_ctrl;
  localparam int DEPTH = 16;

  logic       clk = 0, rst_n = 0, tick = 0, en = 1, flush = 0, done = 0, perr = 0, ready = 0, clr = 0;
  logic [7:0] data = 0;
  logic [4:0] thresh = 0;
  logic [3:0] tochars = 0;
  logic       rd_valid, rd_perr, overrun, timeout, irq;
  logic [7:0] rd_data;
  logic [4:0] level;
  int         n_chk = 0, n_fail = 0;

  uart_rx_buf_ctrl #(.DEPTH(16), .TICKS_PER_CHAR(160), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_tick(tick), .i_enable(en), .i_flush(flush),
    .i_rx_done(done), .i_rx_data(data), .i_rx_parity_err(perr),
    .o_rd_valid(rd_valid), .i_rd_ready(ready), .o_rd_data(rd_data), .o_rd_perr(rd_perr),
    .o_level(level), .i_thresh(thresh), .i_timeout_chars(tochars),
    .o_overrun(overrun), .i_overrun_clr(clr), .o_timeout(timeout), .o_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    done = 0; flush = 0; ready = 0; clr = 0; tick = 0; en = 1; thresh = 0; tochars = 0;
    rst_n = 0;
    #7;
    rst_n = 1;
    cyc();
  endtask

  task automatic send(input logic [7:0] d, input logic p);
    data = d; perr = p; done = 1;
    cyc();
    done = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({level, rd_valid, rd_data, rd_perr, overrun, timeout, irq} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got %h want 0", {level, rd_valid, rd_data, rd_perr, overrun, timeout, irq});
    end
    send(8'h5F, 1); send(8'h11, 0); send(8'h22, 1);
    n_chk++;
    if (level !== 5'd3) begin n_fail++; $display("FAIL pre_async_level got %0d want 3", level); end
    rst_n = 0;
    #2;
    n_chk++;
    if ({level, rd_valid, rd_data, rd_perr, overrun, timeout, irq} !== '0) begin
      n_fail++; $display("FAIL async_reset got %h want 0", {level, rd_valid, rd_data, rd_perr, overrun, timeout, irq});
    end
    #3;
    rst_n = 1;
    cyc();
  endtask

  task automatic test_order();
    logic [8:0] got[$];
    logic [8:0] exp[3] = '{9'h0A5, 9'h13C, 9'h07E};
    do_reset();
    ready = 1;
    for (int i = 0; i < 8; i++) begin
      done = i < 3;
      if (i < 3) {perr, data} = exp[i];
      cyc();
      if (rd_valid) got.push_back({rd_perr, rd_data});
    end
    ready = 0;
    n_chk++;
    if (got.size() != 3) begin n_fail++; $display("FAIL order_count got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== exp[i]) begin n_fail++; $display("FAIL order_entry%0d got %h want %h", i, got[i], exp[i]); end
    end
    n_chk++;
    if (level !== 5'd0) begin n_fail++; $display("FAIL order_level got %0d want 0", level); end
  endtask

  task automatic test_overrun();
    logic [8:0] b[17];
    do_reset();
    for (int i = 0; i < 17; i++) begin
      b[i] = 9'($urandom);
      send(b[i][7:0], b[i][8]);
      if (i == 15) begin
        n_chk++;
        if ({level, overrun} !== {5'd16, 1'b0}) begin n_fail++; $display("FAIL ovr_fill got lvl=%0d ovr=%b want 16/0", level, overrun); end
      end
    end
    n_chk++;
    if ({level, overrun} !== {5'd16, 1'b1}) begin n_fail++; $display("FAIL ovr_drop got lvl=%0d ovr=%b want 16/1", level, overrun); end
    cyc();
    n_chk++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL ovr_irq got %b want 1", irq); end
    clr = 1; done = 1;
    cyc();
    done = 0;
    n_chk++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins got %b want 1", overrun); end
    cyc();
    clr = 0;
    n_chk++;
    if ({overrun, level} !== {1'b0, 5'd16}) begin n_fail++; $display("FAIL ovr_clr got ovr=%b lvl=%0d want 0/16", overrun, level); end
    ready = 1;
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if ({rd_valid, rd_perr, rd_data} !== {1'b1, b[i]}) begin
        n_fail++; $display("FAIL ovr_drain%0d got %h want %h", i, {rd_valid, rd_perr, rd_data}, {1'b1, b[i]});
      end
      cyc();
    end
    ready = 0;
    n_chk++;
    if ({rd_valid, level} !== '0) begin n_fail++; $display("FAIL ovr_empty got v=%b lvl=%0d want 0/0", rd_valid, level); end
  endtask

  task automatic test_full_rw();
    logic [8:0] q[$];
    do_reset();
    for (int i = 0; i < 16; i++) begin
      q.push_back(9'($urandom));
      send(q[i][7:0], q[i][8]);
    end
    ready = 1; data = 8'hEE; perr = 1; done = 1;
    cyc();
    done = 0;
    void'(q.pop_front());
    q.push_back(9'h1EE);
    n_chk++;
    if ({level, overrun} !== {5'd16, 1'b0}) begin n_fail++; $display("FAIL fullrw got lvl=%0d ovr=%b want 16/0", level, overrun); end
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if ({rd_perr, rd_data} !== q[i]) begin n_fail++; $display("FAIL fullrw_drain%0d got %h want %h", i, {rd_perr, rd_data}, q[i]); end
      cyc();
    end
    ready = 0;
  endtask

  task automatic test_thresh();
    do_reset();
    thresh = 4;
    for (int i = 0; i < 4; i++) send(8'($urandom), 0);
    n_chk++;
    if ({level, irq} !== {5'd4, 1'b0}) begin n_fail++; $display("FAIL thr_lag got lvl=%0d irq=%b want 4/0", level, irq); end
    cyc();
    n_chk++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL thr_irq got %b want 1", irq); end
    ready = 1;
    cyc();
    ready = 0;
    n_chk++;
    if ({level, irq} !== {5'd3, 1'b1}) begin n_fail++; $display("FAIL thr_read got lvl=%0d irq=%b want 3/1", level, irq); end
    cyc();
    n_chk++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL thr_clear got %b want 0", irq); end
  endtask

  task automatic test_timeout();
    do_reset();
    tochars = 2;
    send(8'h42, 0);
    cyc(); cyc();
    for (int k = 1; k <= 320; k++) begin
      tick = 1;
      cyc();
      tick = 0;
      cyc();
      if (k == 319) begin
        n_chk++;
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL to_early got %b want 0 at tick 319", timeout); end
      end
    end
    n_chk++;
    if ({timeout, irq} !== 2'b11) begin n_fail++; $display("FAIL to_expire got to=%b irq=%b want 1/1", timeout, irq); end
    ready = 1;
    cyc();
    ready = 0;
    n_chk++;
    if ({timeout, level} !== '0) begin n_fail++; $display("FAIL to_clear got to=%b lvl=%0d want 0/0", timeout, level); end
    cyc();
    n_chk++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL to_irq_clear got %b want 0", irq); end
    tochars = 0;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 17; i++) send(8'($urandom), 0);
    ready = 1;
    repeat (11) cyc();
    ready = 0;
    n_chk++;
    if ({level, overrun} !== {5'd5, 1'b1}) begin n_fail++; $display("FAIL fl_pre got lvl=%0d ovr=%b want 5/1", level, overrun); end
    flush = 1; done = 1; data = 8'h5A; ready = 1;
    cyc();
    flush = 0; done = 0; ready = 0;
    n_chk++;
    if ({level, rd_valid, overrun} !== {5'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL fl_post got lvl=%0d v=%b ovr=%b want 0/0/1", level, rd_valid, overrun);
    end
    send(8'hC3, 1);
    n_chk++;
    if ({level, rd_perr, rd_data} !== {5'd1, 9'h1C3}) begin
      n_fail++; $display("FAIL fl_new got lvl=%0d head=%h want 1/1c3", level, {rd_perr, rd_data});
    end
  endtask

  task automatic test_random();
    logic [8:0] mq[$];
    bit movr, exp_irq, rd, set;
    do_reset();
    thresh = 5'($urandom_range(0, 16));
    movr = 0;
    for (int c = 0; c < 2000; c++) begin
      done  = $urandom_range(0, 9) < 6;
      data  = 8'($urandom);
      perr  = 1'($urandom);
      en    = $urandom_range(0, 9) != 0;
      flush = $urandom_range(0, 49) == 0;
      ready = $urandom_range(0, 9) < 3;
      clr   = $urandom_range(0, 19) == 0;
      exp_irq = (thresh != 0 && mq.size() >= thresh) || movr;
      rd  = mq.size() != 0 && ready && !flush;
      set = 0;
      if (flush) mq.delete();
      else begin
        if (rd) void'(mq.pop_front());
        if (done && en) begin
          if (mq.size() < DEPTH) mq.push_back({perr, data});
          else set = 1;
        end
      end
      movr = set ? 1'b1 : (clr ? 1'b0 : movr);
      cyc();
      n_chk++;
      if ({level, rd_valid, overrun, irq, timeout} !== {5'(mq.size()), mq.size() != 0, movr, exp_irq, 1'b0}) begin
        n_fail++;
        $display("FAIL rnd_state c=%0d got lvl=%0d v=%b ovr=%b irq=%b to=%b want lvl=%0d ovr=%b irq=%b",
                 c, level, rd_valid, overrun, irq, timeout, mq.size(), movr, exp_irq);
      end
      if (mq.size() != 0) begin
        n_chk++;
        if ({rd_perr, rd_data} !== mq[0]) begin n_fail++; $display("FAIL rnd_head c=%0d got %h want %h", c, {rd_perr, rd_data}, mq[0]); end
      end
    end
    done = 0; flush = 0; ready = 0; clr = 0; en = 1;
  endtask

  initial begin
    test_reset();
    test_order();
    test_overrun();
    test_full_rw();
    test_thresh();
    test_timeout();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
